// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter (IFU read-only, LSU read/write) with a single
// outstanding transaction, round-robin on conflict, responses routed to the owner.
module mem_arbiter #(
    parameter int XLEN   = 32,
    parameter int MASK_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ifu_req_valid_i,
    output logic              ifu_req_ready_o,
    input  logic [XLEN-1:0]   ifu_addr_i,
    output logic              ifu_rsp_valid_o,
    output logic [XLEN-1:0]   ifu_rdata_o,
    input  logic              lsu_req_valid_i,
    output logic              lsu_req_ready_o,
    input  logic              lsu_we_i,
    input  logic [XLEN-1:0]   lsu_addr_i,
    input  logic [XLEN-1:0]   lsu_wdata_i,
    input  logic [MASK_W-1:0] lsu_wmask_i,
    output logic              lsu_rsp_valid_o,
    output logic [XLEN-1:0]   lsu_rdata_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [MASK_W-1:0] mem_wmask_o,
    input  logic              mem_rsp_valid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic                we_q, we_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;

    logic                idle;
    logic                issue;
    logic                grant_lsu;
    logic                grant_any;
    logic                rsp_fire;
    logic [XLEN-1:0]     sel_addr;

    // LSU wins when alone, or on conflict when the IFU held the last grant.
    always_comb begin
        idle      = rst_ni && (state_q == IDLE);
        issue     = (state_q == ISSUE);
        grant_lsu = lsu_req_valid_i && (!ifu_req_valid_i || !last_q);
        grant_any = ifu_req_valid_i || lsu_req_valid_i;
        rsp_fire  = (state_q == WAIT) && mem_rsp_valid_i;
        sel_addr  = grant_lsu ? lsu_addr_i : ifu_addr_i;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d = ISSUE;
                    owner_d = grant_lsu;
                    last_d  = grant_lsu;
                    we_d    = grant_lsu && lsu_we_i;
                    addr_d  = sel_addr & ~(XLEN'(3));
                    wdata_d = grant_lsu ? lsu_wdata_i : '0;
                    wmask_d = grant_lsu ? lsu_wmask_i : '0;
                end
            end
            ISSUE: begin
                if (mem_req_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    always_comb begin
        ifu_req_ready_o = idle && ifu_req_valid_i && !grant_lsu;
        lsu_req_ready_o = idle && grant_lsu;

        mem_req_valid_o = issue;
        mem_we_o        = issue && we_q;
        mem_addr_o      = issue ? addr_q  : '0;
        mem_wdata_o     = issue ? wdata_q : '0;
        mem_wmask_o     = issue ? wmask_q : '0;

        // Stores get a zero data word with their acknowledge.
        ifu_rsp_valid_o = rsp_fire && !owner_q;
        ifu_rdata_o     = (rsp_fire && !owner_q) ? mem_rdata_i : '0;
        lsu_rsp_valid_o = rsp_fire && owner_q;
        lsu_rdata_o     = (rsp_fire && owner_q && !we_q) ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter: cycle-by-cycle stimulus with expected outputs.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ifu_v, ifu_rdy, ifu_rsp;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_v, lsu_rdy, lsu_we, lsu_rsp;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_v, mem_rdy, mem_we, mem_rsp;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.XLEN(32), .MASK_W(4)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .ifu_req_valid_i (ifu_v),
        .ifu_req_ready_o (ifu_rdy),
        .ifu_addr_i      (ifu_addr),
        .ifu_rsp_valid_o (ifu_rsp),
        .ifu_rdata_o     (ifu_rdata),
        .lsu_req_valid_i (lsu_v),
        .lsu_req_ready_o (lsu_rdy),
        .lsu_we_i        (lsu_we),
        .lsu_addr_i      (lsu_addr),
        .lsu_wdata_i     (lsu_wdata),
        .lsu_wmask_i     (lsu_wmask),
        .lsu_rsp_valid_o (lsu_rsp),
        .lsu_rdata_o     (lsu_rdata),
        .mem_req_valid_o (mem_v),
        .mem_req_ready_i (mem_rdy),
        .mem_we_o        (mem_we),
        .mem_addr_o      (mem_addr),
        .mem_wdata_o     (mem_wdata),
        .mem_wmask_o     (mem_wmask),
        .mem_rsp_valid_i (mem_rsp),
        .mem_rdata_i     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] iv, ia, lv, we, la, wd, wm, mrdy, mrsp, mrd;
        logic [31:0] irdy, lrdy, mv, mwe, ma, mwd, mwm, irsp, ird, lrsp, lrd;
    } vec_t;

    vec_t tbl[$];
    vec_t rtbl[$];
    vec_t zero_v;

    task automatic apply_vec(input vec_t v, input string name);
        logic [137:0] exp_o, act_o;
        ifu_v     = v.iv[0];
        ifu_addr  = v.ia;
        lsu_v     = v.lv[0];
        lsu_we    = v.we[0];
        lsu_addr  = v.la;
        lsu_wdata = v.wd;
        lsu_wmask = v.wm[3:0];
        mem_rdy   = v.mrdy[0];
        mem_rsp   = v.mrsp[0];
        mem_rdata = v.mrd;
        #2;
        exp_o = {v.irdy[0], v.lrdy[0], v.mv[0], v.mwe[0], v.ma, v.mwd, v.mwm[3:0],
                 v.irsp[0], v.ird, v.lrsp[0], v.lrd};
        act_o = {ifu_rdy, lsu_rdy, mem_v, mem_we, mem_addr, mem_wdata, mem_wmask,
                 ifu_rsp, ifu_rdata, lsu_rsp, lsu_rdata};
        total++;
        if (act_o !== exp_o) begin
            bad++;
            $display("FAIL %s: got irdy=%b lrdy=%b mv=%b we=%b addr=%h wd=%h wm=%h irsp=%b ird=%h lrsp=%b lrd=%h ; want %h",
                     name, ifu_rdy, lsu_rdy, mem_v, mem_we, mem_addr, mem_wdata, mem_wmask,
                     ifu_rsp, ifu_rdata, lsu_rsp, lsu_rdata, exp_o);
        end
    endtask

    initial begin
        zero_v = '{0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0};
        //            iv ia           lv we la           wd        wm  rdy rsp rd               irdy lrdy mv we ma           mwd      mwm irsp ird          lrsp lrd
        // IFU alone, unaligned fetch
        tbl.push_back('{1,'h8000_0006,0,0,0,           0,        0,  0,  0,  0,               1,0, 0,0,0,           0,       0,  0,0,           0,0});
        tbl.push_back('{0,0,          0,0,0,           0,        0,  1,  0,  0,               0,0, 1,0,'h8000_0004, 0,       0,  0,0,           0,0});
        tbl.push_back('{0,0,          0,0,0,           0,        0,  0,  1,  'hDEAD_BEEF,     0,0, 0,0,0,           0,       0,  1,'hDEAD_BEEF, 0,0});
        tbl.push_back('{0,0,          0,0,0,           0,        0,  0,  0,  0,               0,0, 0,0,0,           0,       0,  0,0,           0,0});
        // Both request continuously: LSU, IFU, LSU, IFU
        tbl.push_back('{1,'h200,      1,0,'h105,       0,        0,  0,  0,  0,               0,1, 0,0,0,           0,       0,  0,0,           0,0});
        tbl.push_back('{1,'h200,      1,0,'h105,       0,        0,  1,  0,  0,               0,0, 1,0,'h104,       0,       0,  0,0,           0,0});
        tbl.push_back('{1,'h200,      1,0,'h105,       0,        0,  0,  1,  'hA5A5_A5A5,     0,0, 0,0,0,           0,       0,  0,0,           1,'hA5A5_A5A5});
        tbl.push_back('{1,'h200,      1,0,'h105,       0,        0,  0,  0,  0,               1,0, 0,0,0,           0,       0,  0,0,           0,0});
        tbl.push_back('{1,'h200,      1,0,'h105,       0,        0,  1,  0,  0,               0,0, 1,0,'h200,       0,       0,  0,0,           0,0});
        tbl.push_back('{1,'h200,      1,0,'h105,       0,        0,  0,  1,  'h1234_5678,     0,0, 0,0,0,           0,       0,  1,'h1234_5678, 0,0});
        tbl.push_back('{1,'h200,      1,0,'h105,       0,        0,  0,  0,  0,               0,1, 0,0,0,           0,       0,  0,0,           0,0});
        tbl.push_back('{1,'h200,      1,0,'h105,       0,        0,  1,  0,  0,               0,0, 1,0,'h104,       0,       0,  0,0,           0,0});
        tbl.push_back('{1,'h200,      1,0,'h105,       0,        0,  0,  1,  'h0BAD_F00D,     0,0, 0,0,0,           0,       0,  0,0,           1,'h0BAD_F00D});
        tbl.push_back('{1,'h200,      1,0,'h105,       0,        0,  0,  0,  0,               1,0, 0,0,0,           0,       0,  0,0,           0,0});
        tbl.push_back('{1,'h200,      1,0,'h105,       0,        0,  1,  0,  0,               0,0, 1,0,'h200,       0,       0,  0,0,           0,0});
        tbl.push_back('{1,'h200,      1,0,'h105,       0,        0,  0,  1,  'hCAFE_F00D,     0,0, 0,0,0,           0,       0,  1,'hCAFE_F00D, 0,0});
        tbl.push_back('{0,0,          0,0,0,           0,        0,  0,  0,  0,               0,0, 0,0,0,           0,       0,  0,0,           0,0});
        // LSU store stalled by memory; inputs change after grant, spurious responses in ISSUE
        tbl.push_back('{0,0,          1,1,'h8000_0013, 'hAB00,   2,  0,  0,  0,               0,1, 0,0,0,           0,       0,  0,0,           0,0});
        tbl.push_back('{0,0,          0,1,'hFFFF_FFFF, 'hFFFF_FFFF,'hF,0,0,  0,               0,0, 1,1,'h8000_0010, 'hAB00,  2,  0,0,           0,0});
        tbl.push_back('{0,0,          0,1,'hFFFF_FFFF, 'hFFFF_FFFF,'hF,0,1,  'h5555_5555,     0,0, 1,1,'h8000_0010, 'hAB00,  2,  0,0,           0,0});
        tbl.push_back('{0,0,          0,1,'hFFFF_FFFF, 'hFFFF_FFFF,'hF,0,0,  0,               0,0, 1,1,'h8000_0010, 'hAB00,  2,  0,0,           0,0});
        tbl.push_back('{0,0,          0,1,'hFFFF_FFFF, 'hFFFF_FFFF,'hF,1,1,  'h6666_6666,     0,0, 1,1,'h8000_0010, 'hAB00,  2,  0,0,           0,0});
        // IFU arrives while LSU waits; held off until the store ack completes
        tbl.push_back('{1,'h300,      0,0,0,           0,        0,  0,  0,  0,               0,0, 0,0,0,           0,       0,  0,0,           0,0});
        tbl.push_back('{1,'h300,      0,0,0,           0,        0,  0,  1,  'hFFFF_FFFF,     0,0, 0,0,0,           0,       0,  0,0,           1,0});
        tbl.push_back('{1,'h300,      0,0,0,           0,        0,  0,  1,  'h9999_9999,     1,0, 0,0,0,           0,       0,  0,0,           0,0});
        tbl.push_back('{0,0,          0,0,0,           0,        0,  1,  0,  0,               0,0, 1,0,'h300,       0,       0,  0,0,           0,0});
        tbl.push_back('{0,0,          0,0,0,           0,        0,  0,  1,  'h3333_3333,     0,0, 0,0,0,           0,       0,  1,'h3333_3333, 0,0});
        tbl.push_back('{0,0,          0,0,0,           0,        0,  0,  1,  'h4444_4444,     0,0, 0,0,0,           0,       0,  0,0,           0,0});
        tbl.push_back('{0,0,          0,0,0,           0,        0,  0,  0,  0,               0,0, 0,0,0,           0,       0,  0,0,           0,0});
        // Reset-in-WAIT sequence: setup, then post-reset vectors
        rtbl.push_back('{0,0,         1,0,'h40,        0,        0,  0,  0,  0,               0,1, 0,0,0,           0,       0,  0,0,           0,0});
        rtbl.push_back('{0,0,         0,0,0,           0,        0,  1,  0,  0,               0,0, 1,0,'h40,        0,       0,  0,0,           0,0});
        rtbl.push_back('{0,0,         0,0,0,           0,        0,  0,  1,  'h8888_8888,     0,0, 0,0,0,           0,       0,  0,0,           0,0});
        rtbl.push_back('{1,'h500,     1,0,'h600,       0,        0,  0,  0,  0,               0,1, 0,0,0,           0,       0,  0,0,           0,0});
        rtbl.push_back('{1,'h500,     1,0,'h600,       0,        0,  1,  0,  0,               0,0, 1,0,'h600,       0,       0,  0,0,           0,0});
        rtbl.push_back('{1,'h500,     1,0,'h600,       0,        0,  0,  1,  'h7777_0000,     0,0, 0,0,0,           0,       0,  0,0,           1,'h7777_0000});

        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // Requests and a response asserted during reset must not leak to any output.
        apply_vec('{1,'h10,1,1,'h20,'h30,'hF,1,1,'h1111_1111, 0,0,0,0,0,0,0,0,0,0,0}, "reset");
        @(negedge clk);
        apply_vec(zero_v, "reset_idle");
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            apply_vec(tbl[i], $sformatf("vec%0d", i));
        end

        @(negedge clk);
        apply_vec(rtbl[0], "rst_seq_grant");
        @(negedge clk);
        apply_vec(rtbl[1], "rst_seq_issue");
        @(negedge clk);
        rst_n = 1'b0;
        apply_vec('{0,0,0,0,0,0,0,0,1,'h7777_7777, 0,0,0,0,0,0,0,0,0,0,0}, "rst_in_wait");
        #1 rst_n = 1'b1;
        for (int i = 2; i < rtbl.size(); i++) begin
            @(negedge clk);
            apply_vec(rtbl[i], $sformatf("rst_seq%0d", i));
        end

        @(negedge clk);
        apply_vec(zero_v, "final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
